uart_hex_loader: RTL and testbench

Byte-stream loader sitting between the UART receiver and the pipelined CPU's instruction memory. Consumes received bytes over the UART `rdy`/`rdy_clr` handshake and decodes ASCII hex digits into 32-bit words, most significant nibble first. Each completed word is written to consecutive instruction-memory addresses. Every consumed byte is optionally echoed through the UART transmitter, and line terminators, illegal characters and overflow are handled explicitly.

---
 rtl/uart_hex_loader_pkg.sv | 15 +
 rtl/ascii_hex_decode.sv | 25 ++
 rtl/uart_hex_loader.sv | 165 ++++++++++++++++
 tb/tb_uart_hex_loader.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_hex_loader_pkg.sv
// Shared FSM state type and character constants for the UART hex loader.
package uart_hex_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        ECHO_WAIT,
        WRITE
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam int NIBBLES_PER_WORD = 8;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII classifier: upper-case hex digit, line terminator or other.
module ascii_hex_decode
    import uart_hex_loader_pkg::*;
(
    input  logic [7:0] data,
    output logic       is_hex,
    output logic       is_eol,
    output logic [3:0] nib
);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        is_hex = 1'b0;
        nib    = 4'h0;
        is_eol = (data == ASCII_CR) || (data == ASCII_LF);
        if (data >= 8'h30 && data <= 8'h39) begin
            is_hex = 1'b1;
            nib    = data[3:0];
        end else if (data >= 8'h41 && data <= 8'h46) begin
            is_hex = 1'b1;
            nib    = data[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_hex_loader.sv
// Streams ASCII hex from the UART receiver into instruction memory, one 32-bit word per 8 digits.
// Define UART_HEX_LOADER_ECHO_EN to echo every consumed byte through the UART transmitter.
module uart_hex_loader
    import uart_hex_loader_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              clear,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    output logic              rx_rdy_clr,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_wr_en,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err,
    output logic [3:0]        last_nib
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

    state_t      state;
    logic [7:0]  byte_q;
    logic [31:0] word_sr;
    logic [2:0]  nib_cnt;
    logic        commit;

    logic        dec_hex;
    logic        dec_eol;
    logic [3:0]  dec_nib;
    logic        word_done;
    logic        write_now;

    ascii_hex_decode u_decode (
        .data   (byte_q),
        .is_hex (dec_hex),
        .is_eol (dec_eol),
        .nib    (dec_nib)
    );

    assign word_done = dec_hex && (nib_cnt == 3'(NIBBLES_PER_WORD - 1));

`ifdef UART_HEX_LOADER_ECHO_EN
    // ECHO_WAIT spends one cycle issuing the echo and a second with the strobe visible,
    // so a committed word's imem_we lines up with its echo strobe.
    logic echo_done;
    assign write_now = (state == ECHO_WAIT) && !echo_done && !tx_busy && commit;
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign tx_data   = 8'h00;
    assign tx_wr_en  = 1'b0;
    assign write_now = (state == WRITE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_q     <= 8'h00;
            word_sr    <= 32'h0;
            nib_cnt    <= 3'd0;
            commit     <= 1'b0;
            rx_rdy_clr <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0;
            word_count <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
            last_nib   <= 4'h0;
`ifdef UART_HEX_LOADER_ECHO_EN
            echo_done  <= 1'b0;
            tx_data    <= 8'h00;
            tx_wr_en   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses <= only; strobes default low so each is a single-cycle pulse.
            rx_rdy_clr <= 1'b0;
            imem_we    <= 1'b0;
`ifdef UART_HEX_LOADER_ECHO_EN
            tx_wr_en   <= 1'b0;
`endif
            if (clear) begin
                state      <= IDLE;
                word_count <= '0;
                full       <= 1'b0;
                nib_cnt    <= 3'd0;
                commit     <= 1'b0;
                err        <= 1'b0;
`ifdef UART_HEX_LOADER_ECHO_EN
                echo_done  <= 1'b0;
`endif
            end else begin
                if (write_now) begin
                    if (!full) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_count[ADDR_W-1:0];
                        imem_wdata <= word_sr;
                        word_count <= word_count + (ADDR_W + 1)'(1);
                        full       <= (word_count == LAST_COUNT);
                    end else begin
                        err <= 1'b1;
                    end
                end

                case (state)
                    IDLE: begin
                        if (rx_rdy && load_en) begin
                            byte_q     <= rx_data;
                            rx_rdy_clr <= 1'b1;
                            state      <= DECODE;
                        end
                    end
                    DECODE: begin
                        if (dec_hex) begin
                            word_sr  <= {word_sr[27:0], dec_nib};
                            last_nib <= dec_nib;
                            if (word_done) begin
                                nib_cnt <= 3'd0;
                                commit  <= 1'b1;
                            end else begin
                                nib_cnt <= nib_cnt + 3'd1;
                            end
                        end else if (dec_eol) begin
                            nib_cnt <= 3'd0;
                        end else begin
                            err <= 1'b1;
                        end
`ifdef UART_HEX_LOADER_ECHO_EN
                        state <= ECHO_WAIT;
`else
                        state <= word_done ? WRITE : IDLE;
`endif
                    end
`ifdef UART_HEX_LOADER_ECHO_EN
                    ECHO_WAIT: begin
                        if (echo_done) begin
                            echo_done <= 1'b0;
                            state     <= commit ? WRITE : IDLE;
                        end else if (!tx_busy) begin
                            tx_data   <= byte_q;
                            tx_wr_en  <= 1'b1;
                            echo_done <= 1'b1;
                        end
                    end
`endif
                    WRITE: begin
                        commit <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_hex_loader.sv
// Self-checking bench for uart_hex_loader: vector table, timing corner cases and a randomized
// byte stream scored against a digit-accumulating reference model.
module tb_uart_hex_loader;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;
`ifdef UART_HEX_LOADER_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              load_en;
    logic              clear;
    logic [7:0]        rx_data;
    logic              rx_rdy;
    logic              rx_rdy_clr;
    logic              tx_busy;
    logic [7:0]        tx_data;
    logic              tx_wr_en;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              full;
    logic              err;
    logic [3:0]        last_nib;

    uart_hex_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .clear      (clear),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .rx_rdy_clr (rx_rdy_clr),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_wr_en   (tx_wr_en),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .word_count (word_count),
        .full       (full),
        .err        (err),
        .last_nib   (last_nib)
    );

    always #5 clk = ~clk;

    // ---------------- monitor: records every strobe seen on a falling edge ----------------
    logic [31:0]       wr_data_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [7:0]        echo_q[$];
    int                clr_n = 0;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_data_q.push_back(imem_wdata);
            wr_addr_q.push_back(imem_addr);
        end
        if (tx_wr_en) echo_q.push_back(tx_data);
        if (rx_rdy_clr) clr_n++;
    end

    // ---------------- scoring ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model: digits accumulate into words ----------------
    int          m_nibs;
    int          m_count;
    bit          m_err;
    logic [3:0]  m_last;
    logic [31:0] m_word;
    logic [31:0] m_exp[$];
    logic [7:0]  sent_q[$];
    int          wr_base;
    int          echo_base;

    function automatic int hex_val(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        return -1;
    endfunction

    function automatic logic [7:0] hex_char(input int d);
        return (d < 10) ? 8'(48 + d) : 8'(55 + d);
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int v;
        v = hex_val(b);
        sent_q.push_back(b);
        if (v >= 0) begin
            m_word = (m_word * 32'd16) + 32'(v);
            m_last = 4'(v);
            m_nibs++;
            if (m_nibs == 8) begin
                m_nibs = 0;
                if (m_count < DEPTH) begin
                    m_exp.push_back(m_word);
                    m_count++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (b == 8'h0D || b == 8'h0A) begin
            m_nibs = 0;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic model_restart(input bit full_reset);
        m_nibs  = 0;
        m_count = 0;
        m_err   = 1'b0;
        if (full_reset) m_last = 4'h0;
        m_exp.delete();
        sent_q.delete();
        wr_base   = wr_data_q.size();
        echo_base = echo_q.size();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
        model_restart(1'b0);
    endtask

    // UART receiver behaviour: hold rdy until the acknowledge, drop it at the edge ending DECODE.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        while (!rx_rdy_clr && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("rx_handshake_timeout", 32'(rx_rdy_clr), 32'd1);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        model_byte(b);
    endtask

    task automatic drain(input bit rand_busy);
        int k;
        k = rand_busy ? int'($urandom_range(0, 4)) : 0;
        for (int i = 0; i < k; i++) begin
            tx_busy = 1'($urandom_range(0, 1));
            tick(1);
        end
        tx_busy = 1'b0;
        tick(6);
    endtask

    task automatic send_and_drain(input logic [7:0] b, input bit rand_busy);
        send_byte(b);
        drain(rand_busy);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] ill [6];
        int r;
        ill = '{8'h47, 8'h67, 8'h20, 8'h2F, 8'h3A, 8'h61};
        r = int'($urandom_range(0, 15));
        if (r < 12) return hex_char(int'($urandom_range(0, 15)));
        if (r == 12) return 8'h0D;
        if (r == 13) return 8'h0A;
        return ill[$urandom_range(0, 5)];
    endfunction

    task automatic score_against_model(input string tag);
        int nw;
        int ne;
        nw = wr_data_q.size() - wr_base;
        ne = echo_q.size() - echo_base;
        check({tag, "_writes"}, 32'(nw), 32'(m_exp.size()));
        for (int i = 0; i < nw && i < m_exp.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[wr_base + i]), 32'(i));
            check($sformatf("%s_data%0d", tag, i), wr_data_q[wr_base + i], m_exp[i]);
        end
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_last_nib"}, 32'(last_nib), 32'(m_last));
        check({tag, "_word_count"}, 32'(word_count), 32'(m_count));
        check({tag, "_echo_count"}, 32'(ne), ECHO ? 32'(sent_q.size()) : 32'd0);
        for (int i = 0; i < ne && i < sent_q.size(); i++)
            check($sformatf("%s_echo%0d", tag, i), 32'(echo_q[echo_base + i]), 32'(sent_q[i]));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [127:0] text;
        int           len;
        logic [31:0]  exp_word;
        int           exp_writes;
        logic         exp_err;
        logic [3:0]   exp_last;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [127:0] t, input int len, input logic [31:0] w,
                           input int nw, input logic e, input logic [3:0] l);
        vec_t v;
        v.text = t; v.len = len; v.exp_word = w; v.exp_writes = nw; v.exp_err = e; v.exp_last = l;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] t;
        logic [6:0]   clr_v;
        logic [6:0]   we_v;
        logic [6:0]   tx_v;
        int           nw;
        int           base_c;
        int           base_e;

        rst = 1'b1; load_en = 1'b1; clear = 1'b0;
        rx_data = 8'h00; rx_rdy = 1'b0; tx_busy = 1'b0;
        m_word = 32'h0;
        model_restart(1'b1);

        add_vec(128'("DEADBEEF"),         8,  32'hDEADBEEF, 1, 1'b0, 4'hF);
        add_vec(128'("1234\n00000013"),   13, 32'h00000013, 1, 1'b0, 4'h3);
        add_vec(128'("12G345678"),        9,  32'h12345678, 1, 1'b1, 4'h8);
        add_vec(128'("0123abcd4567"),     12, 32'h01234567, 1, 1'b1, 4'h7);
        add_vec(128'("FFFFFFFF\r"),       9,  32'hFFFFFFFF, 1, 1'b0, 4'hF);
        add_vec(128'("9876\r5"),          6,  32'h00000000, 0, 1'b0, 4'h5);
        add_vec(128'("0000000100000002"), 16, 32'h00000002, 2, 1'b0, 4'h2);

        // reset state
        #12;
        check("rst_rx_rdy_clr", 32'(rx_rdy_clr), 32'd0);
        check("rst_tx_data",    32'(tx_data),    32'd0);
        check("rst_tx_wr_en",   32'(tx_wr_en),   32'd0);
        check("rst_imem_we",    32'(imem_we),    32'd0);
        check("rst_imem_addr",  32'(imem_addr),  32'd0);
        check("rst_imem_wdata", imem_wdata,      32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_full",       32'(full),       32'd0);
        check("rst_err",        32'(err),        32'd0);
        check("rst_last_nib",   32'(last_nib),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        // table-driven vectors
        for (int v = 0; v < vecs.size(); v++) begin
            do_clear();
            t = vecs[v].text;
            for (int i = 0; i < vecs[v].len; i++)
                send_and_drain(t[8*(vecs[v].len-1-i) +: 8], 1'b0);
            nw = wr_data_q.size() - wr_base;
            check($sformatf("vec%0d_writes", v), 32'(nw), 32'(vecs[v].exp_writes));
            if (vecs[v].exp_writes > 0 && nw > 0) begin
                check($sformatf("vec%0d_data", v), wr_data_q[wr_data_q.size()-1], vecs[v].exp_word);
                check($sformatf("vec%0d_addr", v), 32'(wr_addr_q[wr_addr_q.size()-1]),
                      32'(vecs[v].exp_writes - 1));
            end
            check($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_last_nib", v), 32'(last_nib), 32'(vecs[v].exp_last));
            check($sformatf("vec%0d_word_count", v), 32'(word_count), 32'(vecs[v].exp_writes));
            check($sformatf("vec%0d_full", v), 32'(full), 32'd0);
            check($sformatf("vec%0d_echo_count", v), 32'(echo_q.size() - echo_base),
                  ECHO ? 32'(vecs[v].len) : 32'd0);
        end

        // cycle timing of a committing byte with tx_busy low
        do_clear();
        for (int i = 1; i <= 7; i++) send_and_drain(hex_char(i), 1'b0);
        clr_v = '0; we_v = '0; tx_v = '0;
        rx_data = "8";
        rx_rdy  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            clr_v[c] = rx_rdy_clr;
            we_v[c]  = imem_we;
            tx_v[c]  = tx_wr_en;
            if (rx_rdy_clr) begin
                @(posedge clk);
                #1;
                rx_rdy = 1'b0;
            end
        end
        model_byte("8");
        tick(2);
        check("timing_rx_rdy_clr", 32'(clr_v), 32'b0000010);
        check("timing_imem_we",    32'(we_v),  32'b0001000);
        check("timing_tx_wr_en",   32'(tx_v),  ECHO ? 32'b0001000 : 32'd0);
        score_against_model("timing");

        // transmitter held busy for 20 cycles after DECODE
        base_c = clr_n;
        base_e = echo_q.size();
        tx_busy = 1'b1;
        send_byte("5");
        tick(20);
        check("busy_no_echo_while_busy", 32'(echo_q.size() - base_e), 32'd0);
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_echo_after_fall", 32'(tx_wr_en), ECHO ? 32'd1 : 32'd0);
        tick(6);
        check("busy_echo_count", 32'(echo_q.size() - base_e), ECHO ? 32'd1 : 32'd0);
        check("busy_ack_count",  32'(clr_n - base_c), 32'd1);

        // load_en low blocks acceptance of a waiting byte
        base_c = clr_n;
        load_en = 1'b0;
        rx_data = "7";
        rx_rdy  = 1'b1;
        tick(10);
        check("load_en_low_no_ack", 32'(clr_n - base_c), 32'd0);
        load_en = 1'b1;
        send_and_drain("7", 1'b0);
        check("load_en_high_ack", 32'(clr_n - base_c), 32'd1);

        // reset in the middle of a word
        do_clear();
        for (int i = 0; i < 8; i++) send_and_drain("1", 1'b0);
        for (int i = 0; i < 5; i++) send_and_drain(hex_char(10 + i), 1'b0);
        check("pre_reset_word_count", 32'(word_count), 32'd1);
        rst = 1'b1;
        tick(1);
        check("mid_reset_word_count", 32'(word_count), 32'd0);
        check("mid_reset_last_nib",   32'(last_nib),   32'd0);
        rst = 1'b0;
        tick(1);
        model_restart(1'b1);
        t = 128'("13572468");
        for (int i = 0; i < 8; i++) send_and_drain(t[8*(7-i) +: 8], 1'b0);
        check("post_reset_write", (wr_data_q.size() - wr_base == 1) ? wr_data_q[wr_base] : 32'hxxxxxxxx,
              32'h13572468);
        score_against_model("post_reset");

        // random mixed stream with random transmitter stalls
        do_clear();
        for (int i = 0; i < 60; i++) send_and_drain(rand_byte(), 1'b1);
        score_against_model("rand_mixed");

        // random digits: fill memory, then overflow with a 17th word
        do_clear();
        for (int w = 0; w <= DEPTH; w++) begin
            for (int d = 0; d < 8; d++)
                send_and_drain(hex_char(int'($urandom_range(0, 15))), 1'b1);
            if (w == DEPTH - 1) begin
                check("fill_full",       32'(full),       32'd1);
                check("fill_err",        32'(err),        32'd0);
                check("fill_word_count", 32'(word_count), 32'(DEPTH));
            end
        end
        check("overflow_full", 32'(full), 32'd1);
        score_against_model("overflow");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
